// File: rtl/if_fetch.sv
// Instruction-fetch stage: one-entry skid buffer, branch/jump redirect, and discard of stale fetches.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] if_instr,
    output logic [5:0]  if_inscod,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

    state_e      state_q, state_d;
    logic        run_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        valid_q, valid_d;
    logic        redirect;
    logic        load;
    logic [31:0] target;

    // run_q keeps the request low for the first cycle after reset, so a stray ack there is ignored.
    always_comb begin
        redirect  = run_q && (jump || branch_taken);
        target    = jump ? {ipc4_q[31:28], jump_index, 2'b00} : branch_target;
        imem_req  = run_q && (state_q != HOLD);
        imem_addr = (state_q == DISCARD) ? daddr_q : pc_q;
        state_d   = state_q;
        pc_d      = pc_q;
        daddr_d   = daddr_q;
        skid_d    = skid_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        ipc4_d    = ipc4_q;
        valid_d   = valid_q;
        load      = 1'b0;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                        skid_d  = '0;
                        if (!imem_ack) begin
                            state_d = DISCARD;
                            daddr_d = pc_q;
                        end
                    end else if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (!valid_q || !stall) begin
                            load    = 1'b1;
                            instr_d = imem_rdata;
                            ipc_d   = pc_q;
                            ipc4_d  = pc_q + 32'd4;
                            valid_d = 1'b1;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (!stall) begin
                        // Decode consumed the current word and nothing new arrived: insert a bubble.
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                        skid_d  = '0;
                        state_d = FETCH;
                    end else if (!stall) begin
                        // pc already advanced past the skid word, so its address is pc-4.
                        load    = 1'b1;
                        instr_d = skid_q;
                        ipc_d   = pc_q - 32'd4;
                        ipc4_d  = pc_q;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        pc_d = target;
                    end
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
            pc_q    <= '0;
            daddr_q <= '0;
            skid_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            daddr_q <= daddr_d;
            skid_q  <= skid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
        end
    end

    assign if_instr  = instr_q;
    assign if_inscod = instr_q[31:26];
    assign if_pc     = ipc_q;
    assign if_pc4    = ipc4_q;
    assign if_valid  = valid_q;

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fcnt_q, flcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            flcnt_q <= '0;
        end else begin
            if (load)     fcnt_q  <= fcnt_q + 32'd1;
            if (redirect) flcnt_q <= flcnt_q + 32'd1;
        end
    end

    assign fetch_count = fcnt_q;
    assign flush_count = flcnt_q;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, zero-wait and slow memory, stall/skid, jump/branch redirect, discard, wrap.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] if_instr;
    logic [5:0]  if_inscod;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    if_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .if_instr(if_instr), .if_inscod(if_inscod),
        .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef IF_PERF_COUNTERS_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_index = '0;

        // Reset state
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc4", if_pc4, 32'h0);
        chk("rst_fcnt", fetch_count, 32'd0);
        chk("rst_flcnt", flush_count, 32'd0);

        // Release reset with a stray ack that must be ignored
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("start_req", {31'd0, imem_req}, 32'd1);
        chk("start_addr", imem_addr, 32'h0);
        chk("start_valid", {31'd0, if_valid}, 32'd0);
        chk("start_instr", if_instr, 32'h0);

        // Zero-wait memory
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        chk("zw1_valid", {31'd0, if_valid}, 32'd1);
        chk("zw1_inscod", {26'd0, if_inscod}, 32'h08);
        chk("zw1_pc", if_pc, 32'h0);
        chk("zw1_pc4", if_pc4, 32'h4);
        chk("zw1_addr", imem_addr, 32'h4);
        imem_rdata = 32'h3C01_1234;
        @(negedge clk);
        chk("zw2_inscod", {26'd0, if_inscod}, 32'h0F);
        chk("zw2_pc", if_pc, 32'h4);
        chk("zw2_addr", imem_addr, 32'h8);
        chk("zw2_fcnt", fetch_count, cnt(32'd2));

        // 3-cycle latency memory
        imem_ack = 1'b0;
        @(negedge clk);
        chk("slow_addr1", imem_addr, 32'h8);
        chk("slow_req1", {31'd0, imem_req}, 32'd1);
        chk("slow_bubble", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        chk("slow_addr2", imem_addr, 32'h8);
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("slow_instr", if_instr, 32'h1111_1111);
        chk("slow_pc", if_pc, 32'h8);
        chk("slow_valid", {31'd0, if_valid}, 32'd1);
        chk("slow_addr3", imem_addr, 32'hC);
        chk("slow_fcnt", fetch_count, cnt(32'd3));

        // Stall with an ack arriving: word goes into the skid buffer
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_instr", if_instr, 32'h1111_1111);
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            @(negedge clk);
        end
        chk("hold_pc", if_pc, 32'h8);
        stall = 1'b0;
        @(negedge clk);
        chk("skid_instr", if_instr, 32'h2222_2222);
        chk("skid_pc", if_pc, 32'hC);
        chk("skid_pc4", if_pc4, 32'h10);
        chk("skid_valid", {31'd0, if_valid}, 32'd1);
        chk("skid_addr", imem_addr, 32'h10);
        chk("skid_req", {31'd0, imem_req}, 32'd1);
        chk("skid_fcnt", fetch_count, cnt(32'd4));

        // Jump with same-cycle ack: data dropped, pc = {if_pc4[31:28], idx, 00}
        jump = 1'b1; jump_index = 26'h000_0040; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        @(negedge clk);
        jump = 1'b0; imem_ack = 1'b0;
        chk("jmp_addr", imem_addr, 32'h100);
        chk("jmp_valid", {31'd0, if_valid}, 32'd0);
        chk("jmp_instr", if_instr, 32'h2222_2222);
        chk("jmp_flcnt", flush_count, cnt(32'd1));
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        @(negedge clk);
        chk("jmp_fetch", if_instr, 32'h4444_4444);
        chk("jmp_fetch_pc", if_pc, 32'h100);
        chk("jmp_fcnt", fetch_count, cnt(32'd5));

        // Branch while a fetch is outstanding: DISCARD, late data dropped
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        branch_taken = 1'b0;
        chk("dis_addr", imem_addr, 32'h104);
        chk("dis_req", {31'd0, imem_req}, 32'd1);
        chk("dis_valid", {31'd0, if_valid}, 32'd0);
        chk("dis_flcnt", flush_count, cnt(32'd2));
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("dis_newaddr", imem_addr, 32'h80);
        chk("dis_dropped", if_instr, 32'h4444_4444);
        chk("dis_valid2", {31'd0, if_valid}, 32'd0);

        // Jump and branch together: jump wins (if_pc4 = 0x104 -> target 0xC)
        jump = 1'b1; jump_index = 26'h3; branch_taken = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        jump = 1'b0; branch_taken = 1'b0;
        chk("pri_oldaddr", imem_addr, 32'h80);
        chk("pri_flcnt", flush_count, cnt(32'd3));
        imem_ack = 1'b1; imem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pri_addr", imem_addr, 32'hC);
        chk("pri_instr", if_instr, 32'h4444_4444);

        // Redirect inside DISCARD keeps DISCARD, then reset mid-DISCARD
        branch_taken = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        branch_taken = 1'b0; jump = 1'b1; jump_index = 26'h10;
        chk("dis2_addr", imem_addr, 32'hC);
        @(negedge clk);
        jump = 1'b0;
        chk("dis2_stay", imem_addr, 32'hC);
        chk("dis2_req", {31'd0, imem_req}, 32'd1);
        chk("dis2_flcnt", flush_count, cnt(32'd5));
        #2 rst = 1'b1;
        #1;
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_flcnt", flush_count, 32'd0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        @(negedge clk);
        chk("post_req", {31'd0, imem_req}, 32'd1);
        chk("post_addr", imem_addr, 32'h0);
        chk("post_instr", if_instr, 32'h0);

        // pc wrap: branch to 0xFFFF_FFFC with same-cycle ack, then fetch there
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; imem_rdata = 32'h7777_7777;
        @(negedge clk);
        branch_taken = 1'b0; imem_rdata = 32'h0800_0001;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_inscod", {26'd0, if_inscod}, 32'h02);
        chk("wrap_fcnt", fetch_count, cnt(32'd1));
        chk("wrap_flcnt", flush_count, cnt(32'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
